// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-through cache controller: tag/valid storage, lookup FSM,
// 16-word line refill over a valid/ready memory port, drives an external data array.
module dm_cache_ctrl #(
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned INDEX_W  = 10,
    parameter int unsigned OFFSET_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req_valid,
    output logic                cpu_req_ready,
    input  logic                cpu_req_we,
    input  logic [ADDR_W-1:0]   cpu_req_addr,
    input  logic [DATA_W-1:0]   cpu_req_wdata,
    output logic                cpu_resp_valid,
    output logic [DATA_W-1:0]   cpu_resp_rdata,
    output logic                cpu_resp_hit,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    input  logic                mem_rdata_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                data_re,
    output logic                data_we,
    output logic [INDEX_W-1:0]  data_index,
    output logic [OFFSET_W-1:0] data_offset,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W-1:0]   data_rdata
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LINES = 1 << INDEX_W;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StRefillReq,
        StRefillWait,
        StFillRd,
        StRdResp,
        StWrMem,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [OFFSET_W-1:0] cnt_q, cnt_d;
    logic                hit_q, hit_d;
    logic                fill_done;

    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q [LINES];

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [OFFSET_W-1:0] req_offset;
    logic                lookup_hit;

    assign req_tag    = addr_q[ADDR_W-1 -: TAG_W];
    assign req_index  = addr_q[OFFSET_W +: INDEX_W];
    assign req_offset = addr_q[OFFSET_W-1:0];
    assign lookup_hit = valid_q[req_index] && (tag_q[req_index] == req_tag);

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        hit_d     = hit_q;
        fill_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_req_valid) begin
                    we_d    = cpu_req_we;
                    addr_d  = cpu_req_addr;
                    wdata_d = cpu_req_wdata;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                hit_d = lookup_hit;
                if (we_q) begin
                    state_d = StWrMem;
                end else if (lookup_hit) begin
                    state_d = StRdResp;
                end else begin
                    cnt_d   = '0;
                    state_d = StRefillReq;
                end
            end
            StRefillReq: begin
                if (mem_req_ready) state_d = StRefillWait;
            end
            StRefillWait: begin
                if (mem_rdata_valid) begin
                    cnt_d = cnt_q + OFFSET_W'(1);
                    // Line becomes valid only once the final word has landed.
                    if (cnt_q == '1) begin
                        fill_done = 1'b1;
                        state_d   = StFillRd;
                    end else begin
                        state_d = StRefillReq;
                    end
                end
            end
            StFillRd:           state_d = StRdResp;
            StRdResp, StResp:   state_d = StIdle;
            StWrMem: begin
                if (mem_req_ready) state_d = StResp;
            end
            default:            state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            if (fill_done) valid_q[req_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) tag_q[req_index] <= req_tag;
    end

    always_comb begin
        cpu_req_ready  = (state_q == StIdle);
        cpu_resp_valid = (state_q == StRdResp) || (state_q == StResp);
        cpu_resp_rdata = (state_q == StRdResp) ? data_rdata : '0;
        cpu_resp_hit   = cpu_resp_valid && hit_q;

        mem_req_valid  = (state_q == StRefillReq) || (state_q == StWrMem);
        mem_req_we     = (state_q == StWrMem);
        mem_req_addr   = (state_q == StRefillReq) ? {req_tag, req_index, cnt_q} : addr_q;
        mem_req_wdata  = (state_q == StWrMem) ? wdata_q : '0;

        data_re     = ((state_q == StLookup) && !we_q && lookup_hit) || (state_q == StFillRd);
        data_we     = ((state_q == StLookup) && we_q && lookup_hit)
                    || ((state_q == StRefillWait) && mem_rdata_valid);
        data_index  = req_index;
        data_offset = (state_q == StRefillWait) ? cnt_q : req_offset;
        data_wdata  = (state_q == StRefillWait) ? mem_rdata : wdata_q;
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: memory and data-array models plus a cache-state reference
// model; directed scenarios followed by randomized traffic with random stalls/latency.
module tb_dm_cache_ctrl;

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [DATA_W-1:0] cpu_req_wdata;
    logic              cpu_resp_valid, cpu_resp_hit;
    logic [DATA_W-1:0] cpu_resp_rdata;
    logic              mem_req_valid, mem_req_ready, mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_rdata_valid;
    logic [DATA_W-1:0] mem_rdata;
    logic              data_re, data_we;
    logic [9:0]        data_index;
    logic [3:0]        data_offset;
    logic [DATA_W-1:0] data_wdata, data_rdata;

    dm_cache_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_we     (cpu_req_we),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .cpu_resp_hit   (cpu_resp_hit),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_rdata_valid(mem_rdata_valid),
        .mem_rdata      (mem_rdata),
        .data_re        (data_re),
        .data_we        (data_we),
        .data_index     (data_index),
        .data_offset    (data_offset),
        .data_wdata     (data_wdata),
        .data_rdata     (data_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_fail = 0;

    // Environment state: main memory, data array, one pending read return.
    logic [DATA_W-1:0] env_mem [int];
    logic [DATA_W-1:0] darr [16384];
    logic [DATA_W-1:0] rd_next = '0;
    bit                pend = 1'b0;
    int                pend_cnt, pend_addr;
    int                fixed_lat = 1;
    bit                rand_lat = 1'b0;
    bit                rand_ready = 1'b0;
    int                stall_left = 0;
    int                n_mem_rd, n_mem_wr, n_data_we, n_viol;
    int                rd_addrs [$];
    bit                prev_stalled = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic              prev_we;
    logic [DATA_W-1:0] prev_wdata;

    // Reference model of the cache as the CPU should see it.
    bit                ref_valid [1024];
    logic [2:0]        ref_tag [1024];
    logic [DATA_W-1:0] ref_mem [int];

    function automatic logic [DATA_W-1:0] env_rd(input int a);
        return env_mem.exists(a) ? env_mem[a] : DATA_W'(a);
    endfunction

    function automatic logic [DATA_W-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : DATA_W'(a);
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Inputs driven at negedge, everything observed 1 time unit later.
    initial begin
        mem_req_ready   = 1'b1;
        mem_rdata_valid = 1'b0;
        mem_rdata       = '0;
        data_rdata      = '0;
        forever begin
            @(negedge clk);
            data_rdata      = rd_next;
            mem_rdata_valid = 1'b0;
            mem_rdata       = '0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    pend            = 1'b0;
                    mem_rdata_valid = 1'b1;
                    mem_rdata       = env_rd(pend_addr);
                end
            end
            if (stall_left > 0 && mem_req_valid && !mem_req_we && mem_req_addr[3:0] == 4'd5)
                mem_req_ready = 1'b0;
            else if (rand_ready)
                mem_req_ready = ($urandom_range(0, 3) != 0);
            else
                mem_req_ready = 1'b1;
            #1;
            if (prev_stalled && !(mem_req_valid && mem_req_addr == prev_addr
                                  && mem_req_we == prev_we && mem_req_wdata == prev_wdata))
                n_viol++;
            prev_stalled = mem_req_valid && !mem_req_ready;
            prev_addr    = mem_req_addr;
            prev_we      = mem_req_we;
            prev_wdata   = mem_req_wdata;
            if (mem_req_valid && !mem_req_ready && stall_left > 0) stall_left--;
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_we) begin
                    n_mem_wr++;
                    env_mem[int'(mem_req_addr)] = mem_req_wdata;
                end else begin
                    if (pend) n_viol++;
                    n_mem_rd++;
                    rd_addrs.push_back(int'(mem_req_addr));
                    pend      = 1'b1;
                    pend_cnt  = rand_lat ? int'($urandom_range(1, 3)) : fixed_lat;
                    pend_addr = int'(mem_req_addr);
                end
            end
            if (data_re && data_we) n_viol++;
            if (data_we) begin
                n_data_we++;
                darr[{data_index, data_offset}] = data_wdata;
            end
            if (data_re) rd_next = darr[{data_index, data_offset}];
        end
    end

    task automatic clear_counts();
        n_mem_rd  = 0;
        n_mem_wr  = 0;
        n_data_we = 0;
        rd_addrs.delete();
    endtask

    task automatic do_req(input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                          output int lat, output logic hit, output logic [DATA_W-1:0] rd,
                          output bit timed_out);
        int t0;
        timed_out = 1'b1;
        lat = 0;
        hit = 1'b0;
        rd = '0;
        @(negedge clk);
        clear_counts();
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = wd;
        #2;
        t0 = cyc;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        for (int k = 0; k < 500; k++) begin
            #2;
            if (cpu_resp_valid) begin
                lat = cyc - t0;
                hit = cpu_resp_hit;
                rd = cpu_resp_rdata;
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic txn(input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                       input bit chk_lat, input int extra);
        int                idx, lat, exp_lat;
        logic [2:0]        tg;
        bit                exp_hit, to, seq_ok;
        logic              hit;
        logic [DATA_W-1:0] rd, exp_rd;
        idx     = int'(addr[13:4]);
        tg      = addr[16:14];
        exp_hit = ref_valid[idx] && ref_tag[idx] == tg;
        exp_rd  = we ? '0 : ref_rd(int'(addr));
        if (we) ref_mem[int'(addr)] = wd;
        do_req(we, addr, wd, lat, hit, rd, to);
        check($sformatf("timeout@%05h", addr), 64'(to), 64'(0));
        check($sformatf("hit@%05h", addr), 64'(hit), 64'(exp_hit));
        check($sformatf("rdata@%05h", addr), 64'(rd), 64'(exp_rd));
        check($sformatf("mem_rd@%05h", addr), 64'(n_mem_rd), 64'((!we && !exp_hit) ? 16 : 0));
        check($sformatf("mem_wr@%05h", addr), 64'(n_mem_wr), 64'(we ? 1 : 0));
        check($sformatf("data_we@%05h", addr), 64'(n_data_we),
              64'(we ? (exp_hit ? 1 : 0) : (exp_hit ? 0 : 16)));
        if (!we && !exp_hit) begin
            seq_ok = (rd_addrs.size() == 16);
            for (int k = 0; k < 16 && seq_ok; k++)
                if (rd_addrs[k] != int'({tg, addr[13:4], 4'(k)})) seq_ok = 1'b0;
            check($sformatf("refill_seq@%05h", addr), 64'(seq_ok), 64'(1));
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
        end
        if (chk_lat) begin
            exp_lat = we ? 3 : (exp_hit ? 2 : 35);
            check($sformatf("latency@%05h", addr), 64'(lat), 64'(exp_lat + extra));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int               idx_list [5] = '{0, 1, 2, 1023, 5};
        logic [ADDR_W-1:0] a;
        bit               seen;
        rst           = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_wdata = '0;
        n_viol        = 0;
        clear_counts();
        for (int i = 0; i < 1024; i++) ref_valid[i] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        check("reset_ready", 64'(cpu_req_ready), 64'(1));
        check("reset_resp_valid", 64'(cpu_resp_valid), 64'(0));
        check("reset_mem_req_valid", 64'(mem_req_valid), 64'(0));
        check("reset_data_we", 64'(data_we), 64'(0));
        check("reset_data_re", 64'(data_re), 64'(0));

        txn(1'b0, 17'h00010, '0, 1'b1, 0);
        txn(1'b0, 17'h00013, '0, 1'b1, 0);
        txn(1'b0, 17'h04010, '0, 1'b1, 0);
        txn(1'b0, 17'h00010, '0, 1'b1, 0);
        txn(1'b0, 17'h04010, '0, 1'b1, 0);
        txn(1'b1, 17'h04012, 32'h0001_ABCD, 1'b1, 0);
        txn(1'b0, 17'h04012, '0, 1'b1, 0);
        txn(1'b1, 17'h18000, 32'hDEAD_0001, 1'b1, 0);
        txn(1'b0, 17'h00005, '0, 1'b1, 0);
        txn(1'b0, 17'h03FF7, '0, 1'b1, 0);
        txn(1'b0, 17'h03FF0, '0, 1'b1, 0);

        // Refill with word 5 held off for three cycles.
        stall_left = 3;
        txn(1'b0, 17'h08020, '0, 1'b1, 3);
        check("stall_consumed", 64'(stall_left), 64'(0));

        // Reset while word 7's return is still in flight.
        fixed_lat = 3;
        @(negedge clk);
        clear_counts();
        cpu_req_valid = 1'b1;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = 17'h0C030;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            #2;
            if (n_mem_rd == 8) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reset_test_word7", 64'(seen), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        n_data_we = 0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("ready_after_reset", 64'(cpu_req_ready), 64'(1));
        for (int i = 0; i < 1024; i++) ref_valid[i] = 1'b0;
        repeat (4) @(negedge clk);
        check("late_return_ignored", 64'(n_data_we), 64'(0));
        check("late_return_done", 64'(pend), 64'(0));
        fixed_lat = 1;
        txn(1'b0, 17'h0C030, '0, 1'b1, 0);
        txn(1'b0, 17'h00013, '0, 1'b1, 0);

        // Random traffic over a handful of contended lines.
        rand_ready = 1'b1;
        rand_lat   = 1'b1;
        for (int n = 0; n < 40; n++) begin
            a = {3'($urandom_range(0, 7)), 10'(idx_list[$urandom_range(0, 4)]),
                 4'($urandom_range(0, 15))};
            txn(1'($urandom_range(0, 1)), a, $urandom, 1'b0, 0);
        end
        check("protocol_violations", 64'(n_viol), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
